// File: rtl/csb_to_periph_bridge_if.sv
// Bus interfaces for the CSB-to-peripheral bridge: the NVDLA CSB request/response
// channel and the HWPE peripheral (register-file) master channel.
interface nvdla_csb_intf;
    logic        valid;
    logic [15:0] addr;
    logic [31:0] wdat;
    logic        write;
    logic        nposted;
    logic        ready;
    logic        r_valid;
    logic [31:0] r_data;
    logic        wr_complete;

    modport master (
        output valid, addr, wdat, write, nposted,
        input  ready, r_valid, r_data, wr_complete
    );
    modport slave (
        input  valid, addr, wdat, write, nposted,
        output ready, r_valid, r_data, wr_complete
    );
endinterface

interface hwpe_ctrl_intf_periph #(
    parameter int unsigned ID_WIDTH = 2
);
    logic                req;
    logic [31:0]         add;
    logic                wen;
    logic [3:0]          be;
    logic [31:0]         data;
    logic [ID_WIDTH-1:0] id;
    logic                gnt;
    logic [31:0]         r_data;
    logic                r_valid;
    logic [ID_WIDTH-1:0] r_id;

    modport master (
        output req, add, wen, be, data, id,
        input  gnt, r_data, r_valid, r_id
    );
    modport slave (
        input  req, add, wen, be, data, id,
        output gnt, r_data, r_valid, r_id
    );
endinterface

// File: rtl/csb_to_periph_bridge.sv
// Single-outstanding CSB responder that replays each CSB request as one HWPE peripheral
// transaction. Optional watchdog enabled by defining CSB_TO_PERIPH_TIMEOUT_EN.
module csb_to_periph_bridge #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned ID_WIDTH       = 2,
    parameter int unsigned TXN_ID         = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    nvdla_csb_intf.slave                csb,
    hwpe_ctrl_intf_periph.master        periph,
    output logic                        timeout_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

    logic [1:0]          state;
    logic                write_q;
    logic                nposted_q;
    logic [ID_WIDTH-1:0] txn_id;
    logic                accept;
    logic                rsp_match;
    logic                tmo_hit;
    logic                finish;
    logic [31:0]         finish_data;
    logic [31:0]         add_next;

    assign txn_id    = ID_WIDTH'(TXN_ID);
    assign accept    = (state == S_IDLE) && csb.ready && csb.valid;
    assign rsp_match = periph.r_valid && (periph.r_id == txn_id);
    assign add_next  = BASE_ADDR | {14'b0, csb.addr, 2'b00};

    // A transaction ends either on its own response or on a watchdog abort; a real
    // response wins when both land in the same cycle.
    assign finish = ((state == S_ISSUE) && !periph.gnt && tmo_hit) ||
                    ((state == S_WAIT) && (rsp_match || tmo_hit));
    assign finish_data = ((state == S_WAIT) && rsp_match) ? periph.r_data : ABORT_DATA;

    assign periph.be = 4'hF;
    assign periph.id = txn_id;

`ifdef CSB_TO_PERIPH_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt;

    assign tmo_hit = ((state == S_ISSUE) || (state == S_WAIT)) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt   <= 8'd0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= tmo_hit && !(state == S_ISSUE && periph.gnt) && !(state == S_WAIT && rsp_match);
            if (accept)
                tmo_cnt <= 8'd0;
            else if ((state == S_ISSUE) || (state == S_WAIT))
                tmo_cnt <= tmo_cnt + 8'd1;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            write_q         <= 1'b0;
            nposted_q       <= 1'b0;
            csb.ready       <= 1'b0;
            csb.r_valid     <= 1'b0;
            csb.r_data      <= 32'h0;
            csb.wr_complete <= 1'b0;
            periph.req      <= 1'b0;
            periph.add      <= 32'h0;
            periph.wen      <= 1'b1;
            periph.data     <= 32'h0;
        end else begin
            csb.r_valid     <= 1'b0;
            csb.wr_complete <= 1'b0;
            case (state)
                S_IDLE: begin
                    csb.ready <= 1'b1;
                    if (accept) begin
                        csb.ready   <= 1'b0;
                        write_q     <= csb.write;
                        nposted_q   <= csb.nposted;
                        periph.req  <= 1'b1;
                        periph.add  <= add_next;
                        periph.wen  <= ~csb.write;
                        periph.data <= csb.wdat;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (periph.gnt) begin
                        periph.req <= 1'b0;
                        state      <= S_WAIT;
                    end
                end
                S_RESP: begin
                    csb.ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: ;
            endcase
            // Shared completion path for both a normal response and a watchdog abort
            if (finish) begin
                periph.req <= 1'b0;
                state      <= S_RESP;
                if (!write_q) begin
                    csb.r_valid <= 1'b1;
                    csb.r_data  <= finish_data;
                end else if (nposted_q) begin
                    csb.wr_complete <= 1'b1;
                end
            end
        end
    end

endmodule
